// File: rtl/led_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_multi
//  Description : Multi-channel LED controller. Each channel selects OFF, ON,
//                retriggerable activity hold or blink; a fixed-priority
//                arbiter (channel 0 highest) picks the channel that drives
//                the LED pin, and a global PWM stage sets brightness.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_ctrl_multi #(
    parameter int CHANNELS = 4,
    parameter int DELAY    = 21_480_000,
    parameter int BLINK    = 2_148_000,
    parameter int PWM_BITS = 4,
    localparam int OWNER_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET_n,
    input  logic [2*CHANNELS-1:0]   Mode,
    input  logic [CHANNELS-1:0]     Req,
    input  logic [PWM_BITS-1:0]     Brightness,
    output logic                    LedPort,
    output logic [CHANNELS-1:0]     ChanLevel,
    output logic [OWNER_W-1:0]      Owner,
    output logic                    OwnerValid
);

    localparam int HOLD_W  = $clog2(DELAY + 1);
    localparam int BLINK_W = $clog2(BLINK);

    localparam logic [1:0]         MODE_OFF   = 2'd0;
    localparam logic [1:0]         MODE_ON    = 2'd1;
    localparam logic [1:0]         MODE_ACT   = 2'd2;
    localparam logic [1:0]         MODE_BLINK = 2'd3;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(DELAY);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK - 1);
    localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK / 2);

    // ready_q stays low for the first edge after reset release, which keeps
    // every output and counter at zero through that edge.
    logic                  ready_q, ready_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic                  led_q, led_d;
    logic [CHANNELS-1:0]   chan_q, chan_d;
    logic [OWNER_W-1:0]    owner_q, owner_d;
    logic                  valid_q, valid_d;

    logic [CHANNELS-1:0]   raw_lvl;
    logic                  any_blink;
    logic                  blink_phase;
    logic                  owner_lvl;
    logic                  gate;

    assign blink_phase = (blink_cnt_q < BLINK_HALF);

    // Per-channel hold counter and raw level.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [1:0]        mode_i;
        logic [HOLD_W-1:0] hold_q, hold_d;

        assign mode_i = Mode[2*gi +: 2];

        assign raw_lvl[gi] = (mode_i == MODE_ON)
                           | ((mode_i == MODE_ACT) & (Req[gi] | (hold_q != '0)))
                           | ((mode_i == MODE_BLINK) & blink_phase);

        // Hold next value: cleared outside ACT, loaded on Req, else counts down to 0.
        always_comb begin
            hold_d = '0;
            if (ready_q && (mode_i == MODE_ACT)) begin
                if (Req[gi]) begin
                    hold_d = HOLD_LOAD;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end
            end
        end

        // Hold counter register.
        always_ff @(posedge CLK or negedge RESET_n) begin
            if (!RESET_n) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end
    end

    // Detect whether any channel is currently in blink mode.
    always_comb begin
        any_blink = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (Mode[2*i +: 2] == MODE_BLINK) begin
                any_blink = 1'b1;
            end
        end
    end

    // Shared counters: PWM free-runs, blink counter runs only while a channel blinks.
    always_comb begin
        ready_d     = 1'b1;
        pwm_cnt_d   = '0;
        blink_cnt_d = '0;
        if (ready_q) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            if (any_blink && (blink_cnt_q != BLINK_LAST)) begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Priority arbitration, PWM gating and output next values.
    always_comb begin
        owner_d   = '0;
        valid_d   = 1'b0;
        owner_lvl = 1'b0;
        // Scan from the top so the lowest-index active channel wins.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (Mode[2*i +: 2] != MODE_OFF) begin
                owner_d   = OWNER_W'(i);
                valid_d   = 1'b1;
                owner_lvl = raw_lvl[i];
            end
        end
        gate   = (&Brightness) | (pwm_cnt_q < Brightness);
        led_d  = owner_lvl & gate & valid_d;
        chan_d = raw_lvl;
        if (!ready_q) begin
            owner_d = '0;
            valid_d = 1'b0;
            led_d   = 1'b0;
            chan_d  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ready_q     <= 1'b0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            led_q       <= 1'b0;
            chan_q      <= '0;
            owner_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
            chan_q      <= chan_d;
            owner_q     <= owner_d;
            valid_q     <= valid_d;
        end
    end

    assign LedPort    = led_q;
    assign ChanLevel  = chan_q;
    assign Owner      = owner_q;
    assign OwnerValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_ctrl_multi
//  Description : Directed self-checking bench for led_ctrl_multi
//                (CHANNELS=4, DELAY=10, BLINK=8, PWM_BITS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_ctrl_multi;

    localparam int CHANNELS = 4;
    localparam int DELAY    = 10;
    localparam int BLINK    = 8;
    localparam int PWM_BITS = 4;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic [7:0] Mode;
    logic [3:0] Req;
    logic [3:0] Brightness;
    logic       LedPort;
    logic [3:0] ChanLevel;
    logic [1:0] Owner;
    logic       OwnerValid;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    led_ctrl_multi #(
        .CHANNELS (CHANNELS),
        .DELAY    (DELAY),
        .BLINK    (BLINK),
        .PWM_BITS (PWM_BITS)
    ) u_dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .Mode       (Mode),
        .Req        (Req),
        .Brightness (Brightness),
        .LedPort    (LedPort),
        .ChanLevel  (ChanLevel),
        .Owner      (Owner),
        .OwnerValid (OwnerValid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int hi;
        int lvl;

        // ---------------- reset, ch1 BLINK ----------------
        RESET_n    = 1'b1;
        Mode       = 8'h0C;
        Req        = 4'h0;
        Brightness = 4'hF;
        #2 RESET_n = 1'b0;
        #1;
        check("rst_led",   32'(LedPort),    32'd0);
        check("rst_valid", 32'(OwnerValid), 32'd0);
        step();
        step();
        RESET_n = 1'b1;
        // edge 1 after release dark, then 4 high / 4 low
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 1) check("rel_e1_led", 32'(LedPort), 32'd0);
            else        check($sformatf("blink_e%0d", k), 32'(LedPort), 32'(((k - 2) % 8) < 4));
            if (k == 2) begin
                check("rel_owner", 32'(Owner),      32'd1);
                check("rel_valid", 32'(OwnerValid), 32'd1);
                check("rel_chan",  32'(ChanLevel),  32'h2);
            end
        end
        // mid-period asynchronous reset
        step();
        RESET_n = 1'b0;
        #1;
        check("mid_rst_led",   32'(LedPort),    32'd0);
        check("mid_rst_chan",  32'(ChanLevel),  32'd0);
        check("mid_rst_owner", 32'(Owner),      32'd0);
        check("mid_rst_valid", 32'(OwnerValid), 32'd0);
        step();
        step();
        RESET_n = 1'b1;
        step();
        check("rerel_e1_led", 32'(LedPort), 32'd0);
        step();
        check("rerel_e2_led", 32'(LedPort), 32'd1);

        // ---------------- activity hold, ch0 ACT ----------------
        Mode = 8'h02;
        step();
        step();
        check("act_idle", 32'(LedPort), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            Req = (k == 1) ? 4'h1 : 4'h0;
            step();
            check($sformatf("act_e%0d", k), 32'(LedPort), 32'(k <= 11));
        end

        // ---------------- retrigger ----------------
        for (int k = 1; k <= 17; k++) begin
            Req = (k == 1 || k == 6) ? 4'h1 : 4'h0;
            step();
            check($sformatf("retrig_e%0d", k), 32'(LedPort), 32'(k <= 16));
        end
        Req = 4'h0;

        // ACT -> ON -> ACT with no Req
        Mode = 8'h01;
        step();
        check("on_pulse", 32'(LedPort), 32'd1);
        Mode = 8'h02;
        step();
        check("back_act_e1", 32'(LedPort), 32'd0);
        step();
        check("back_act_e2", 32'(LedPort), 32'd0);

        // ---------------- priority ----------------
        Mode = 8'h1C;   // ch1 BLINK, ch2 ON
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("prio_blink_e%0d", k), 32'(LedPort), 32'(((k - 1) % 8) < 4));
            if (k == 1) begin
                check("prio_owner1", 32'(Owner),     32'd1);
                check("prio_chan",   32'(ChanLevel), 32'h6);
            end
        end
        Mode = 8'h10;   // ch1 OFF, ch2 ON
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("prio_on_e%0d", k), 32'(LedPort), 32'd1);
        end
        check("prio_owner2", 32'(Owner), 32'd2);
        Mode = 8'h00;
        step();
        check("alloff_valid", 32'(OwnerValid), 32'd0);
        check("alloff_led",   32'(LedPort),    32'd0);
        check("alloff_owner", 32'(Owner),      32'd0);

        // ---------------- PWM, ch0 ON ----------------
        Mode = 8'h01;
        for (int b = 0; b < 3; b++) begin
            Brightness = (b == 0) ? 4'd4 : ((b == 1) ? 4'd15 : 4'd0);
            hi  = 0;
            lvl = 0;
            for (int k = 0; k < 16; k++) begin
                step();
                hi  += int'(LedPort);
                lvl += int'(ChanLevel[0]);
            end
            check($sformatf("pwm_hi_b%0d", Brightness), 32'(hi),
                  (b == 0) ? 32'd4 : ((b == 1) ? 32'd16 : 32'd0));
            check($sformatf("pwm_lvl_b%0d", Brightness), 32'(lvl), 32'd16);
        end

        // ---------------- ignored Req, ch0 ON owns, ch3 ACT ----------------
        Brightness = 4'hF;
        Mode       = 8'h81;
        step();
        for (int k = 1; k <= 12; k++) begin
            Req = (k == 1) ? 4'hB : 4'h0;   // ch0, ch1, ch3 strobed
            step();
            check($sformatf("ign_ch3_e%0d", k), 32'(ChanLevel[3]), 32'(k <= 11));
            check($sformatf("ign_led_e%0d", k), 32'(LedPort),      32'd1);
            if (k == 1) begin
                check("ign_ch1", 32'(ChanLevel[1]), 32'd0);
                check("ign_own", 32'(Owner),        32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
